// File: rtl/com_pkg.sv
// Shared constants and types for the centre-of-mass colour scheduler.
// Colour codes match the COM block's colorSelect encoding.
package com_pkg;

  localparam logic [1:0] COLOR_RED   = 2'd0;
  localparam logic [1:0] COLOR_GREEN = 2'd1;
  localparam logic [1:0] COLOR_BLUE  = 2'd2;
  localparam int         NUM_COLORS  = 3;

  localparam logic [9:0] DEFAULT_X = 10'd360;
  localparam logic [9:0] DEFAULT_Y = 10'd240;

  typedef enum logic {
    ACCUM = 1'b0,
    WAIT  = 1'b1
  } state_t;

  typedef struct packed {
    logic [1:0] color;
    logic [9:0] x;
    logic [9:0] y;
  } capture_t;

  // Round-robin successor over red -> green -> blue -> red.
  function automatic logic [1:0] color_inc(input logic [1:0] c);
    return (c >= COLOR_BLUE) ? COLOR_RED : c + 2'd1;
  endfunction

endpackage

// File: rtl/com_next_color.sv
// Picks the next enabled colour after cur: tries cur+1, cur+2, then cur itself.
// none flags an all-disabled mask so the caller can hold its selection.
module com_next_color
  import com_pkg::*;
(
  input  logic [1:0] cur,
  input  logic [2:0] mask,
  output logic [1:0] next,
  output logic       none
);

  logic [1:0] c1;
  logic [1:0] c2;
  logic [3:0] m4;

  always_comb begin
    c1   = color_inc(cur);
    c2   = color_inc(c1);
    // Pad to 4 bits so the 2-bit colour index never selects out of range.
    m4   = {1'b0, mask};
    none = (mask == 3'b000);
    if (m4[c1])      next = c1;
    else if (m4[c2]) next = c2;
    else             next = cur;
  end

endmodule

// File: rtl/com_color_scheduler.sv
// Frame-rate scheduler: rotates the shared COM datapath over enabled colours and
// captures xCenter/yCenter per colour once the divider latency has elapsed.
module com_color_scheduler #(
  parameter int         DIV_LATENCY = 40,
  parameter int         CNT_W       = 6,
  parameter logic [9:0] DEFAULT_X   = com_pkg::DEFAULT_X,
  parameter logic [9:0] DEFAULT_Y   = com_pkg::DEFAULT_Y
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] x,
  input  logic [9:0]  y,
  input  logic [2:0]  enableMask,
  input  logic [9:0]  xCenter,
  input  logic [9:0]  yCenter,
  output logic [1:0]  colorSelect,
  output logic        resultValid,
  output logic [1:0]  resultColor,
  output logic [9:0]  resultX,
  output logic [9:0]  resultY,
  output logic [29:0] centersX,
  output logic [29:0] centersY,
  output logic        overrun
);

  localparam int               NC      = com_pkg::NUM_COLORS;
  localparam logic [CNT_W-1:0] LAT     = CNT_W'(DIV_LATENCY);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  com_pkg::state_t    state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         color_q, color_d;
  logic [1:0]         pend_q, pend_d;
  logic               primed_q, primed_d;
  logic               overrun_q, overrun_d;
  logic               origin_dly_q, origin_dly_d;
  logic               res_vld_q, res_vld_d;
  com_pkg::capture_t  res_q, res_d;
  logic [NC-1:0][9:0] cx_q, cx_d;
  logic [NC-1:0][9:0] cy_q, cy_d;

  logic       origin;
  logic       frame_start;
  logic [1:0] nxt_color;
  logic       nxt_none;

  assign origin      = (x == 11'd0) && (y == 10'd0);
  assign frame_start = origin & ~origin_dly_q;

  com_next_color u_next (
    .cur  (color_q),
    .mask (enableMask),
    .next (nxt_color),
    .none (nxt_none)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    color_d      = color_q;
    pend_d       = pend_q;
    primed_d     = primed_q;
    overrun_d    = overrun_q;
    origin_dly_d = origin;
    res_vld_d    = 1'b0;
    res_d        = res_q;
    cx_d         = cx_q;
    cy_d         = cy_q;

    if (frame_start) begin
      // A boundary inside WAIT abandons the capture in flight.
      if (state_q == com_pkg::WAIT) overrun_d = 1'b1;
      if (nxt_none) begin
        primed_d = 1'b0;
        state_d  = com_pkg::ACCUM;
        cnt_d    = '0;
      end else begin
        pend_d  = color_q;
        color_d = nxt_color;
        if (primed_q) begin
          state_d = com_pkg::WAIT;
          cnt_d   = LAT;
        end else begin
          primed_d = 1'b1;
          state_d  = com_pkg::ACCUM;
          cnt_d    = '0;
        end
      end
    end else if (state_q == com_pkg::WAIT) begin
      // Divider restarts while the origin pixel persists.
      if (origin) begin
        cnt_d = LAT;
      end else if (cnt_q == CNT_ONE) begin
        res_vld_d = 1'b1;
        res_d     = '{color: pend_q, x: xCenter, y: yCenter};
        for (int c = 0; c < NC; c++) begin
          if (pend_q == 2'(c)) begin
            cx_d[c] = xCenter;
            cy_d[c] = yCenter;
          end
        end
        state_d = com_pkg::ACCUM;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= com_pkg::ACCUM;
      cnt_q        <= '0;
      color_q      <= com_pkg::COLOR_RED;
      pend_q       <= com_pkg::COLOR_RED;
      primed_q     <= 1'b0;
      overrun_q    <= 1'b0;
      origin_dly_q <= 1'b0;
      res_vld_q    <= 1'b0;
      res_q        <= '{color: com_pkg::COLOR_RED, x: DEFAULT_X, y: DEFAULT_Y};
      cx_q         <= {NC{DEFAULT_X}};
      cy_q         <= {NC{DEFAULT_Y}};
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      color_q      <= color_d;
      pend_q       <= pend_d;
      primed_q     <= primed_d;
      overrun_q    <= overrun_d;
      origin_dly_q <= origin_dly_d;
      res_vld_q    <= res_vld_d;
      res_q        <= res_d;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
    end
  end

  assign colorSelect = color_q;
  assign resultValid = res_vld_q;
  assign resultColor = res_q.color;
  assign resultX     = res_q.x;
  assign resultY     = res_q.y;
  assign centersX    = cx_q;
  assign centersY    = cy_q;
  assign overrun     = overrun_q;

endmodule
